matrix_dut: RTL and testbench



---
 rtl/matrix_pkg.sv | 79 +++++++
 rtl/systolic_pe.sv | 48 ++++
 rtl/matrix_dut.sv | 125 ++++++++++++
 tb/tb_matrix_dut.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared constants, FSM state type and minifloat arithmetic for the 3x3 matrix multiplier.
// Number format: bit7 sign, bits6:4 exponent (bias 3), bits3:0 fraction; E=0 is subnormal.
// No Inf/NaN: overflow saturates to +/-31.0 and every zero result is +0.
package matrix_pkg;

  localparam int DATA_W = 8;
  localparam int EXP_W  = 3;
  localparam int MAN_W  = 4;
  localparam int BIAS   = 3;
  localparam int N      = 3;
  localparam int PROD_W = 2 * (MAN_W + 1);

  localparam logic [DATA_W-1:0] FP_ZERO = 8'h00;
  localparam logic [DATA_W-1:0] FP_MAX  = 8'h7F;

  typedef enum logic [1:0] {LOAD, COMPUTE, DONE} state_e;

  // Packs sign * mag * 2^(exp_base - BIAS - MAN_W) into the minifloat format,
  // truncating toward zero.
  function automatic logic [DATA_W-1:0] fp_pack(input logic              sign,
                                                input logic [PROD_W-1:0] mag,
                                                input int                exp_base);
    int                h;
    int                e;
    logic [PROD_W-1:0] sig;
    if (mag == '0) return FP_ZERO;
    h = 0;
    for (int i = 0; i < PROD_W; i++) begin
      if (mag[i]) h = i;
    end
    e   = exp_base + h - MAN_W;
    // Leading one lands on bit MAN_W (the hidden bit).
    sig = (h >= MAN_W) ? (mag >> (h - MAN_W)) : (mag << (MAN_W - h));
    if (e > (2 ** EXP_W) - 1) return {sign, FP_MAX[DATA_W-2:0]};
    if (e >= 1) return {sign, EXP_W'(e), sig[MAN_W-1:0]};
    // Below the normal range: denormalise, shifting out bits toward zero.
    sig = sig >> (1 - e);
    if (sig == '0) return FP_ZERO;
    return {sign, {EXP_W{1'b0}}, sig[MAN_W-1:0]};
  endfunction

  function automatic logic [DATA_W-1:0] fp_mul(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [MAN_W:0]    sa;
    logic [MAN_W:0]    sb;
    logic [PROD_W-1:0] p;
    int                ea;
    int                eb;
    sa = {a[DATA_W-2:MAN_W] != '0, a[MAN_W-1:0]};
    sb = {b[DATA_W-2:MAN_W] != '0, b[MAN_W-1:0]};
    ea = (a[DATA_W-2:MAN_W] == '0) ? 1 : int'(a[DATA_W-2:MAN_W]);
    eb = (b[DATA_W-2:MAN_W] == '0) ? 1 : int'(b[DATA_W-2:MAN_W]);
    p  = {{(MAN_W+1){1'b0}}, sa} * {{(MAN_W+1){1'b0}}, sb};
    return fp_pack(a[DATA_W-1] ^ b[DATA_W-1], p, ea + eb - BIAS - MAN_W);
  endfunction

  function automatic logic [DATA_W-1:0] fp_add(input logic [DATA_W-1:0] x,
                                               input logic [DATA_W-1:0] y);
    logic [MAN_W:0]   sx, sy, s_big, s_small, s_al;
    logic [EXP_W-1:0] ex, ey, e_big, e_small;
    logic [MAN_W+1:0] r;
    logic             sgn_big;
    ex = (x[DATA_W-2:MAN_W] == '0) ? EXP_W'(1) : x[DATA_W-2:MAN_W];
    ey = (y[DATA_W-2:MAN_W] == '0) ? EXP_W'(1) : y[DATA_W-2:MAN_W];
    sx = {x[DATA_W-2:MAN_W] != '0, x[MAN_W-1:0]};
    sy = {y[DATA_W-2:MAN_W] != '0, y[MAN_W-1:0]};
    // {exponent, significand} orders magnitudes, so the subtraction never goes negative.
    if ({ex, sx} >= {ey, sy}) begin
      e_big = ex; s_big = sx; e_small = ey; s_small = sy; sgn_big = x[DATA_W-1];
    end else begin
      e_big = ey; s_big = sy; e_small = ex; s_small = sx; sgn_big = y[DATA_W-1];
    end
    s_al = s_small >> (e_big - e_small);
    if (x[DATA_W-1] == y[DATA_W-1]) r = {1'b0, s_big} + {1'b0, s_al};
    else                            r = {1'b0, s_big} - {1'b0, s_al};
    return fp_pack(sgn_big, {{(PROD_W-MAN_W-2){1'b0}}, r}, int'(e_big));
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// Output-stationary multiply-accumulate cell.
// a_i/b_i are forwarded one cycle later on a_o (right) and b_o (down); valid_i
// travels with a. When valid_i is high the accumulator adds a_i*b_i.
// Ports: clk_i, rst_ni (synchronous, active-low), a_i, b_i, valid_i, a_o, b_o,
// valid_o, acc_o (running sum).
module systolic_pe import matrix_pkg::*; (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              valid_i,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] acc_o
);

  logic [DATA_W-1:0] a_d, a_q, b_d, b_q, acc_d, acc_q;
  logic              valid_d, valid_q;

  always_comb begin
    a_d     = a_i;
    b_d     = b_i;
    valid_d = valid_i;
    acc_d   = acc_q;
    if (valid_i) acc_d = fp_add(acc_q, fp_mul(a_i, b_i));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      a_q     <= FP_ZERO;
      b_q     <= FP_ZERO;
      valid_q <= 1'b0;
      acc_q   <= FP_ZERO;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      acc_q   <= acc_d;
    end
  end

  assign a_o     = a_q;
  assign b_o     = b_q;
  assign valid_o = valid_q;
  assign acc_o   = acc_q;

endmodule

// File: rtl/matrix_dut.sv
// 3x3 minifloat matrix multiplier C = A x B on a 3x3 output-stationary systolic array.
// One LOAD edge captures all operands, seven COMPUTE edges stream skewed rows of A
// rightward and columns of B downward, then DONE holds the result until reset.
// Ports: clk, reset (synchronous, active-low), a00..a22 / b00..b22 row-major operands,
// M1_out..M9_out row-major C elements driven straight from the PE accumulators, done (sticky).
module matrix_dut import matrix_pkg::*; (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] a00, a01, a02, a10, a11, a12, a20, a21, a22,
  input  logic [DATA_W-1:0] b00, b01, b02, b10, b11, b12, b20, b21, b22,
  output logic [DATA_W-1:0] M1_out, M2_out, M3_out, M4_out, M5_out,
  output logic [DATA_W-1:0] M6_out, M7_out, M8_out, M9_out,
  output logic              done
);

  localparam int LAST_STEP = 3 * N - 3;

  state_e            state_d, state_q;
  logic [2:0]        step_d, step_q;
  logic [DATA_W-1:0] a_in [N][N];
  logic [DATA_W-1:0] b_in [N][N];
  logic [DATA_W-1:0] a_d [N][N];
  logic [DATA_W-1:0] a_q [N][N];
  logic [DATA_W-1:0] b_d [N][N];
  logic [DATA_W-1:0] b_q [N][N];

  logic [DATA_W-1:0] a_feed [N];
  logic [DATA_W-1:0] b_feed [N];
  logic              v_feed [N];

  // a_h[i][j] / v_h[i][j] enter PE(i,j) from the left; b_v[i][j] enters it from above.
  logic [DATA_W-1:0] a_h [N][N+1];
  logic              v_h [N][N+1];
  logic [DATA_W-1:0] b_v [N+1][N];
  logic [DATA_W-1:0] acc [N][N];

  assign a_in = '{'{a00, a01, a02}, '{a10, a11, a12}, '{a20, a21, a22}};
  assign b_in = '{'{b00, b01, b02}, '{b10, b11, b12}, '{b20, b21, b22}};

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      LOAD: begin
        a_d     = a_in;
        b_d     = b_in;
        step_d  = '0;
        state_d = COMPUTE;
      end
      COMPUTE: begin
        if (step_q == 3'(LAST_STEP)) state_d = DONE;
        else                         step_d  = step_q + 3'd1;
      end
      DONE:    state_d = DONE;
      default: state_d = LOAD;
    endcase
  end

  // Edge skew: row i of A and column i of B start i steps late, so that element k
  // reaches PE(i,j) at step i+j+k through the pass-through registers.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_feed[i] = FP_ZERO;
      b_feed[i] = FP_ZERO;
      v_feed[i] = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (state_q == COMPUTE && int'(step_q) == i + k) begin
          a_feed[i] = a_q[i][k];
          b_feed[i] = b_q[k][i];
          v_feed[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= LOAD;
      step_q  <= '0;
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_feed
    assign a_h[i][0] = a_feed[i];
    assign v_h[i][0] = v_feed[i];
    assign b_v[0][i] = b_feed[i];
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      systolic_pe u_pe (
        .clk_i   (clk),
        .rst_ni  (reset),
        .a_i     (a_h[i][j]),
        .b_i     (b_v[i][j]),
        .valid_i (v_h[i][j]),
        .a_o     (a_h[i][j+1]),
        .b_o     (b_v[i+1][j]),
        .valid_o (v_h[i][j+1]),
        .acc_o   (acc[i][j])
      );
    end
  end

  assign M1_out = acc[0][0];
  assign M2_out = acc[0][1];
  assign M3_out = acc[0][2];
  assign M4_out = acc[1][0];
  assign M5_out = acc[1][1];
  assign M6_out = acc[1][2];
  assign M7_out = acc[2][0];
  assign M8_out = acc[2][1];
  assign M9_out = acc[2][2];
  assign done   = (state_q == DONE);

endmodule

// File: tb/tb_matrix_dut.sv
module tb_matrix_dut;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] a_t [3][3];
  logic [7:0] b_t [3][3];
  logic [7:0] m_o [9];
  logic       done;
  logic [7:0] exp_c [9];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  matrix_dut dut (
    .clk    (clk),
    .reset  (reset),
    .a00    (a_t[0][0]), .a01 (a_t[0][1]), .a02 (a_t[0][2]),
    .a10    (a_t[1][0]), .a11 (a_t[1][1]), .a12 (a_t[1][2]),
    .a20    (a_t[2][0]), .a21 (a_t[2][1]), .a22 (a_t[2][2]),
    .b00    (b_t[0][0]), .b01 (b_t[0][1]), .b02 (b_t[0][2]),
    .b10    (b_t[1][0]), .b11 (b_t[1][1]), .b12 (b_t[1][2]),
    .b20    (b_t[2][0]), .b21 (b_t[2][1]), .b22 (b_t[2][2]),
    .M1_out (m_o[0]), .M2_out (m_o[1]), .M3_out (m_o[2]),
    .M4_out (m_o[3]), .M5_out (m_o[4]), .M6_out (m_o[5]),
    .M7_out (m_o[6]), .M8_out (m_o[7]), .M9_out (m_o[8]),
    .done   (done)
  );

  // ---------------- reference model: values as integers in units of 1/64 ----------------
  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int dec(input logic [7:0] x);
    int e, f, mag;
    e   = int'(x[6:4]);
    f   = int'(x[3:0]);
    mag = (e == 0) ? f : ((16 + f) << (e - 1));
    return x[7] ? -mag : mag;
  endfunction

  // Largest representable magnitude not above m64 (already floored to 1/64).
  function automatic logic [7:0] enc(input logic neg, input int m64);
    int         e;
    logic [7:0] r;
    if (m64 == 0) return 8'h00;
    if (m64 >= 2048) r = 8'h7F;
    else if (m64 < 16) r = 8'(m64);
    else begin
      e = 1;
      while (m64 >= (32 << (e - 1))) e++;
      r = {1'b0, 3'(e), 4'((m64 >> (e - 1)) - 16)};
    end
    return {neg, r[6:0]};
  endfunction

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = dec(a) * dec(b);
    return enc(p < 0, iabs(p) / 64);
  endfunction

  // The smaller operand is cut to the step size of the larger operand's exponent first.
  function automatic logic [7:0] m_add(input logic [7:0] x, input logic [7:0] y);
    int vb, vs, eb, ulp, ts, s;
    if (iabs(dec(x)) >= iabs(dec(y))) begin
      vb = dec(x); vs = dec(y); eb = int'(x[6:4]);
    end else begin
      vb = dec(y); vs = dec(x); eb = int'(y[6:4]);
    end
    ulp = 1 << (((eb < 1) ? 1 : eb) - 1);
    ts  = (iabs(vs) / ulp) * ulp;
    s   = vb + ((vs < 0) ? -ts : ts);
    return enc(s < 0, iabs(s));
  endfunction

  task automatic compute_expected;
    logic [7:0] acc;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        acc = 8'h00;
        for (int k = 0; k < 3; k++) acc = m_add(acc, m_mul(a_t[i][k], b_t[k][j]));
        exp_c[i*3+j] = acc;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [7:0] rnd_fp();
    logic [7:0] x;
    x = 8'($urandom);
    if ($urandom_range(0, 1) == 1) x[6] = 1'b0;
    return x;
  endfunction

  task automatic rand_ops;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        a_t[i][j] = rnd_fp();
        b_t[i][j] = rnd_fp();
      end
  endtask

  task automatic do_reset;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rand_ops();
    do_reset();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL reset done: got %b want 0", done);
    end
    for (int n = 0; n < 9; n++) begin
      checks++;
      if (m_o[n] !== 8'h00) begin
        errors++; $display("FAIL reset M%0d: got %h want 00", n + 1, m_o[n]);
      end
    end
  endtask

  task automatic test_nominal;
    logic [7:0] want [9];
    want = '{8'h40, 8'h42, 8'h42, 8'h00, 8'h38, 8'h38, 8'h34, 8'h18, 8'h18};
    a_t = '{'{8'h20, 8'h20, 8'h30}, '{8'h20, 8'h30, 8'hB8}, '{8'h90, 8'h20, 8'h30}};
    b_t = '{'{8'h30, 8'h44, 8'h44}, '{8'h30, 8'h30, 8'h30}, '{8'h30, 8'h20, 8'h20}};
    do_reset();
    reset = 1'b1;
    repeat (7) step();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL nominal done@7: got %b want 0", done);
    end
    step();
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL nominal done@8: got %b want 1", done);
    end
    for (int n = 0; n < 9; n++) begin
      checks++;
      if (m_o[n] !== want[n]) begin
        errors++; $display("FAIL nominal M%0d: got %h want %h", n + 1, m_o[n], want[n]);
      end
    end
  endtask

  task automatic test_identity;
    a_t = '{'{8'h30, 8'h00, 8'h00}, '{8'h00, 8'h30, 8'h00}, '{8'h00, 8'h00, 8'h30}};
    b_t = '{'{8'h30, 8'h44, 8'h44}, '{8'h30, 8'h30, 8'h30}, '{8'h30, 8'h20, 8'h20}};
    do_reset();
    reset = 1'b1;
    repeat (8) step();
    for (int n = 0; n < 9; n++) begin
      checks++;
      if (m_o[n] !== b_t[n/3][n%3]) begin
        errors++; $display("FAIL identity M%0d: got %h want %h", n + 1, m_o[n], b_t[n/3][n%3]);
      end
    end
  endtask

  task automatic test_zeros;
    logic [7:0] zv [2];
    zv = '{8'h00, 8'h80};
    for (int z = 0; z < 2; z++) begin
      rand_ops();
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) a_t[i][j] = zv[z];
      do_reset();
      reset = 1'b1;
      repeat (8) step();
      checks++;
      if (done !== 1'b1) begin
        errors++; $display("FAIL zeros%0d done@8: got %b want 1", z, done);
      end
      for (int n = 0; n < 9; n++) begin
        checks++;
        if (m_o[n] !== 8'h00) begin
          errors++; $display("FAIL zeros%0d M%0d: got %h want 00", z, n + 1, m_o[n]);
        end
      end
    end
  endtask

  task automatic test_saturation;
    logic [7:0] av [2];
    logic [7:0] want [2];
    av   = '{8'h50, 8'hD0};
    want = '{8'h7F, 8'hFF};
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          a_t[i][j] = av[s];
          b_t[i][j] = 8'h50;
        end
      do_reset();
      reset = 1'b1;
      repeat (8) step();
      for (int n = 0; n < 9; n++) begin
        checks++;
        if (m_o[n] !== want[s]) begin
          errors++; $display("FAIL sat%0d M%0d: got %h want %h", s, n + 1, m_o[n], want[s]);
        end
      end
    end
  endtask

  task automatic test_random;
    for (int r = 0; r < 150; r++) begin
      rand_ops();
      compute_expected();
      do_reset();
      reset = 1'b1;
      repeat (7) step();
      checks++;
      if (done !== 1'b0) begin
        errors++; $display("FAIL random%0d done@7: got %b want 0", r, done);
      end
      step();
      checks++;
      if (done !== 1'b1) begin
        errors++; $display("FAIL random%0d done@8: got %b want 1", r, done);
      end
      for (int n = 0; n < 9; n++) begin
        checks++;
        if (m_o[n] !== exp_c[n]) begin
          errors++;
          $display("FAIL random%0d M%0d: got %h want %h", r, n + 1, m_o[n], exp_c[n]);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    for (int r = 0; r < 4; r++) begin
      rand_ops();
      do_reset();
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      step();
      checks++;
      if (done !== 1'b0) begin
        errors++; $display("FAIL midreset%0d done: got %b want 0", r, done);
      end
      for (int n = 0; n < 9; n++) begin
        checks++;
        if (m_o[n] !== 8'h00) begin
          errors++; $display("FAIL midreset%0d clear M%0d: got %h want 00", r, n + 1, m_o[n]);
        end
      end
      rand_ops();
      compute_expected();
      reset = 1'b1;
      repeat (7) step();
      checks++;
      if (done !== 1'b0) begin
        errors++; $display("FAIL midreset%0d done@7: got %b want 0", r, done);
      end
      step();
      checks++;
      if (done !== 1'b1) begin
        errors++; $display("FAIL midreset%0d done@8: got %b want 1", r, done);
      end
      for (int n = 0; n < 9; n++) begin
        checks++;
        if (m_o[n] !== exp_c[n]) begin
          errors++;
          $display("FAIL midreset%0d M%0d: got %h want %h", r, n + 1, m_o[n], exp_c[n]);
        end
      end
    end
  endtask

  task automatic test_hold;
    rand_ops();
    compute_expected();
    do_reset();
    reset = 1'b1;
    step();
    rand_ops();  // operands were captured on the LOAD edge; these must be ignored
    repeat (7) step();
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL hold done@8: got %b want 1", done);
    end
    for (int n = 0; n < 9; n++) begin
      checks++;
      if (m_o[n] !== exp_c[n]) begin
        errors++; $display("FAIL hold M%0d: got %h want %h", n + 1, m_o[n], exp_c[n]);
      end
    end
    for (int e = 0; e < 20; e++) begin
      if (e == 10) rand_ops();
      step();
      checks++;
      if (done !== 1'b1) begin
        errors++; $display("FAIL hold+%0d done: got %b want 1", e, done);
      end
      for (int n = 0; n < 9; n++) begin
        checks++;
        if (m_o[n] !== exp_c[n]) begin
          errors++; $display("FAIL hold+%0d M%0d: got %h want %h", e, n + 1, m_o[n], exp_c[n]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_identity();
    test_zeros();
    test_saturation();
    test_random();
    test_reset_mid();
    test_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
